dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bridge directly downstream of the MEM stage of the 5-stage MIPS pipeline. Converts the stage's single-cycle `mem_ren`/`mem_wen`/`mem_addr`/`mem_dout` interface into a req/ack bus to a variable-latency data memory. Returns read data on `mem_din`, and drives `mem_stall` to the pipeline controller to freeze all stages while an access is outstanding. A fault flag reports a bus timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles in REQ without `bus_ack` before the request is aborted. Range 1..255.
- `FAULT_DATA`, default 32'hDEAD_BEEF: value returned on `mem_din` for a read that timed out.

Ports:
- `clk` in 1: main clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_ren` in 1: read request from the MEM stage.
- `mem_wen` in 1: write request from the MEM stage.
- `mem_addr` in 32: byte address, word-aligned. Bits [1:0] are passed through unchanged.
- `mem_dout` in 32: write data from the pipeline.
- `mem_din` out 32: read data to the pipeline, used by the WB stage and MEM forwarding.
- `mem_stall` out 1: freeze request to the pipeline controller. Combinational.
- `mem_fault` out 1: sticky timeout flag.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: 1 for write, 0 for read.
- `bus_addr` out 32: bus address.
- `bus_wdata` out 32: bus write data.
- `bus_ack` in 1: single-cycle completion strobe from the slave.
- `bus_rdata` in 32: read data, valid only in the cycle `bus_ack` is high.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE**, no access requested: `mem_stall` = 0.
- **IDLE**, `mem_ren` or `mem_wen` high:
  - Latch the address, write data and direction into registers.
  - Set `mem_stall` = 1 in the same cycle.
  - Move to REQ.
  - If both `mem_ren` and `mem_wen` are high, the write wins and the read is ignored.
- **REQ**: `bus_req` = 1.
  - `bus_we`, `bus_addr` and `bus_wdata` are held stable until ack.
  - `mem_stall` = 1.
  - The timeout counter increments each cycle.
  - On `bus_ack`: capture `bus_rdata` (reads only), clear the counter, move to DONE.
  - When the counter reaches `TIMEOUT_CYCLES` without ack: drop `bus_req`, load `FAULT_DATA` into the read register (reads only), set `mem_fault`, move to DONE.
- **DONE**: `mem_stall` = 0, so the pipeline advances at the end of this cycle. Always returns to IDLE next.
  - The MEM-stage request is still visible in this cycle and is not reissued.
- `mem_din` is the read-data register.
  - It holds its value until the next read completes.
  - It is stable throughout DONE and the following WB cycle.
- Write completion leaves `mem_din` unchanged.
- `bus_ack` is ignored in IDLE and DONE.
- `mem_fault` clears only on `rst`.
- Reset values:
  - State = IDLE; `bus_req` = 0; `bus_we` = 0.
  - `bus_addr` = 0; `bus_wdata` = 0; `mem_din` = 0.
  - `mem_fault` = 0; `mem_stall` = 0; counter = 0.
- Reset mid-transaction: `bus_req` drops at the reset edge. The slave must tolerate an abandoned request, and a late `bus_ack` is ignored.

## Timing
- Access seen in IDLE at cycle 0. `bus_req` is high from cycle 1.
- `bus_ack` at cycle k (k ≥ 1) leads to DONE at cycle k+1 and IDLE at cycle k+2.
- Stall cycles = k + 1 per access. The minimum (ack in cycle 1) is 2 stall cycles.
- Back-to-back accesses: the next instruction's access is accepted in the IDLE cycle after DONE, so there is one bubble-free IDLE cycle.
- Timeout: DONE is reached at cycle `TIMEOUT_CYCLES` + 1.

## Configuration
- `DMEM_WBUF_EN` defined: writes are posted.
  - In IDLE, a write with the buffer empty is latched, `mem_stall` = 0 that cycle, and the state goes to REQ with a posted flag set.
  - Posted ack or timeout returns to IDLE, skipping DONE.
  - Any CPU access that arrives while the bridge is not in IDLE stalls until the posted write drains. This preserves read-after-write ordering.
  - A read behind a pending write is issued only after that write's ack.
- `DMEM_WBUF_EN` not defined: writes are blocking, exactly like reads (stall through REQ, complete via DONE).

## Structure
- Shared header for the constants:
  - State encodings `DMEM_IDLE`/`DMEM_REQ`/`DMEM_DONE` (2-bit).
  - `FAULT_DATA` default.
- One sub-module, `dmem_wbuf`: holds the address/data/posted-flag registers. It is instantiated in both configurations; the posted logic is active only under `DMEM_WBUF_EN`.
- The timeout counter is 8-bit and lives inline.

## Test plan
- Read, addr 0x0000_0040, ack after 3 cycles with rdata 0x1234_5678:
  - `mem_stall` is high for 4 cycles.
  - `mem_din` = 0x1234_5678 from DONE onward.
  - `bus_req` is high for exactly 3 cycles.
- Write, addr 0x80, data 0xA5A5_A5A5, ack in cycle 1, `DMEM_WBUF_EN` off:
  - 2 stall cycles; `bus_we` = 1; `bus_wdata` is stable.
  - `mem_din` is unchanged.
- Simultaneous `mem_ren` and `mem_wen`: `bus_we` = 1, and exactly one bus transaction is issued.
- No ack, `TIMEOUT_CYCLES` = 4, read:
  - `bus_req` drops after 4 cycles.
  - `mem_din` = 0xDEAD_BEEF and `mem_fault` = 1, held until `rst`.
- `DMEM_WBUF_EN` on, write followed by a read, slave ack latency 2:
  - The write cycle shows `mem_stall` = 0.
  - The read stalls until the write acks, then its own `bus_req` issues.
  - The bus order is write then read.
- `rst` asserted in the second REQ cycle, ack arriving one cycle later:
  - All outputs take their reset values.
  - The ack is ignored and the state stays IDLE.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared constants for the data-memory bridge: FSM state encodings and fault data.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_REQ  = 2'b01,
    DMEM_DONE = 2'b10
  } dmem_state_t;

  localparam logic [31:0] DMEM_FAULT_DATA = 32'hDEAD_BEEF;
  localparam int unsigned DMEM_TO_W       = 8;

  // Last counter value seen in REQ before the request is abandoned.
  function automatic logic [DMEM_TO_W-1:0] dmem_to_last(input int unsigned limit);
    return DMEM_TO_W'(limit - 1);
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Address/data/direction holding registers for the outstanding bus access.
// The posted flag is set only when DMEM_WBUF_EN is defined.
module dmem_wbuf
  import dmem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        drain,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        posted
);

  always_ff @(posedge clk) begin
    if (rst) begin
      we     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      posted <= 1'b0;
    end else if (load) begin
      we    <= load_we;
      addr  <= load_addr;
      wdata <= load_data;
`ifdef DMEM_WBUF_EN
      posted <= load_we;
`else
      posted <= 1'b0;
`endif
    end else if (drain) begin
      posted <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage to req/ack data-memory bridge with pipeline stall and sticky timeout fault.
// DMEM_WBUF_EN defined: writes are posted and do not stall the pipeline.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] FAULT_DATA     = DMEM_FAULT_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [DMEM_TO_W-1:0] TO_LAST = dmem_to_last(TIMEOUT_CYCLES);

  dmem_state_t          state;
  logic [DMEM_TO_W-1:0] to_cnt;
  logic                 accept;
  logic                 to_hit;
  logic                 drain;
  logic                 posted;
  logic                 cpu_access;

  assign cpu_access = mem_ren | mem_wen;
  assign accept     = (state == DMEM_IDLE) && cpu_access;
  assign to_hit     = (to_cnt == TO_LAST);
  assign drain      = (state == DMEM_REQ) && (bus_ack || to_hit);

  // Write wins over read when both are requested in the same cycle.
  dmem_wbuf u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_we   (mem_wen),
    .load_addr (mem_addr),
    .load_data (mem_dout),
    .drain     (drain),
    .we        (bus_we),
    .addr      (bus_addr),
    .wdata     (bus_wdata),
    .posted    (posted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DMEM_IDLE;
      bus_req   <= 1'b0;
      to_cnt    <= '0;
      mem_din   <= '0;
      mem_fault <= 1'b0;
    end else begin
      unique case (state)
        DMEM_IDLE: begin
          if (accept) begin
            state   <= DMEM_REQ;
            bus_req <= 1'b1;
            to_cnt  <= '0;
          end
        end
        DMEM_REQ: begin
          if (bus_ack) begin
            if (!bus_we) mem_din <= bus_rdata;
            bus_req <= 1'b0;
            to_cnt  <= '0;
            state   <= posted ? DMEM_IDLE : DMEM_DONE;
          end else if (to_hit) begin
            if (!bus_we) mem_din <= FAULT_DATA;
            mem_fault <= 1'b1;
            bus_req   <= 1'b0;
            to_cnt    <= '0;
            state     <= posted ? DMEM_IDLE : DMEM_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DMEM_DONE: state <= DMEM_IDLE;
        default:   state <= DMEM_IDLE;
      endcase
    end
  end

  // A posted write only holds the pipeline when another access arrives behind it.
  always_comb begin
    mem_stall = 1'b0;
    unique case (state)
`ifdef DMEM_WBUF_EN
      DMEM_IDLE: mem_stall = accept && !mem_wen;
`else
      DMEM_IDLE: mem_stall = accept;
`endif
      DMEM_REQ:  mem_stall = posted ? cpu_access : 1'b1;
      DMEM_DONE: mem_stall = 1'b0;
      default:   mem_stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: vector table, scoreboard queue, reset and posted-write sequences.
module tb_dmem_bridge;

`ifdef DMEM_WBUF_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_stall, mem_fault;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  dmem_bridge #(.TIMEOUT_CYCLES(4), .FAULT_DATA(32'hDEAD_BEEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_stall (mem_stall),
    .mem_fault (mem_fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned lat;       // ack in this REQ cycle; 0 = never
    int unsigned exp_stall;
    int unsigned exp_req;
    logic        exp_we;
    logic [31:0] exp_din;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus_rdata = $urandom;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t        e;
    int unsigned stall_n = 0, req_n = 0, txn = 0, cyc = 0;
    logic        prev_req = 1'b0, we_seen = 1'b0, stable = 1'b1, done = 1'b0;
    mem_ren  = v.ren;
    mem_wen  = v.wen;
    mem_addr = v.addr;
    mem_dout = v.wdata;
    sb.push_back(v);
    while (!done && cyc < 40) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (bus_req) begin
        req_n++;
        if (!prev_req) txn++;
        we_seen = bus_we;
        if (bus_addr !== v.addr || bus_wdata !== v.wdata) stable = 1'b0;
        if (req_n == v.lat) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rdata;
        end
      end
      prev_req = bus_req;
      if (mem_stall) stall_n++;
      else begin
        done = 1'b1;
        if (sb.size() == 0) chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
        else begin
          e = sb.pop_front();
          chk($sformatf("v%0d_stall_cycles", idx), stall_n, e.exp_stall);
          chk($sformatf("v%0d_req_cycles", idx), req_n, e.exp_req);
          chk($sformatf("v%0d_txn_count", idx), txn, 32'd1);
          chk($sformatf("v%0d_bus_we", idx), {31'd0, we_seen}, {31'd0, e.exp_we});
          chk($sformatf("v%0d_bus_stable", idx), {31'd0, stable}, 32'd1);
          chk($sformatf("v%0d_din_done", idx), mem_din, e.exp_din);
          chk($sformatf("v%0d_fault", idx), {31'd0, mem_fault}, {31'd0, e.exp_fault});
        end
      end
      tick();
      bus_ack = 1'b0;
      cyc++;
    end
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    chk($sformatf("v%0d_completed", idx), {31'd0, done}, 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d_din_wb", idx), mem_din, v.exp_din);
    chk($sformatf("v%0d_idle_req", idx), {31'd0, bus_req}, 32'd0);
    chk($sformatf("v%0d_idle_stall", idx), {31'd0, mem_stall}, 32'd0);
    tick();
  endtask

  task automatic reset_seq();
    mem_ren  = 1'b1;
    mem_addr = 32'h0000_0300;
    mem_dout = 32'h0;
    bus_ack  = 1'b0;
    @(negedge clk);
    chk("rst_seq_stall_idle", {31'd0, mem_stall}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_seq_req_before", {31'd0, bus_req}, 32'd1);
    tick();
    rst       = 1'b0;
    mem_ren   = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("rst_seq_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_seq_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_seq_bus_addr", bus_addr, 32'd0);
    chk("rst_seq_bus_wdata", bus_wdata, 32'd0);
    chk("rst_seq_mem_din", mem_din, 32'd0);
    chk("rst_seq_fault", {31'd0, mem_fault}, 32'd0);
    chk("rst_seq_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", {31'd0, bus_req}, 32'd0);
    chk("late_ack_din", mem_din, 32'd0);
    tick();
    @(negedge clk);
    chk("late_ack_still_idle", {31'd0, bus_req}, 32'd0);
    tick();
  endtask

`ifdef DMEM_WBUF_EN
  task automatic posted_seq();
    logic        order[$];
    int unsigned rq = 0, rd_stall = 0, cyc = 0;
    logic        prev_req = 1'b0, done = 1'b0;
    mem_wen  = 1'b1;
    mem_addr = 32'h0000_0200;
    mem_dout = 32'h0000_0077;
    @(negedge clk);
    chk("posted_wr_nostall", {31'd0, mem_stall}, 32'd0);
    tick();
    mem_wen  = 1'b0;
    mem_ren  = 1'b1;
    mem_addr = 32'h0000_0204;
    while (!done && cyc < 30) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (bus_req) begin
        if (!prev_req) begin
          order.push_back(bus_we);
          rq = 1;
        end else rq++;
        if (rq == 2) begin
          bus_ack   = 1'b1;
          bus_rdata = 32'h0000_0099;
        end
      end
      prev_req = bus_req;
      if (mem_stall) rd_stall++;
      else done = 1'b1;
      tick();
      bus_ack = 1'b0;
      cyc++;
    end
    mem_ren = 1'b0;
    chk("posted_rd_done", {31'd0, done}, 32'd1);
    chk("posted_rd_stall", rd_stall, 32'd5);
    chk("posted_txn_count", order.size(), 32'd2);
    if (order.size() == 2) begin
      chk("posted_order_first_we", {31'd0, order[0]}, 32'd1);
      chk("posted_order_second_rd", {31'd0, order[1]}, 32'd0);
    end
    chk("posted_rd_din", mem_din, 32'h0000_0099);
    tick();
  endtask
`endif

  initial begin
    //         ren   wen   addr          wdata         rdata         lat stl req we    din           fault
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678, 3, 4, 3, 1'b0, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 32'hFFFF_0000, 1, 2, 1, 1'b1, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 32'h1111_1111, 2, 3, 2, 1'b1, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0000_0001, 32'hCAFE_BABE, 1, 2, 1, 1'b0, 32'hCAFE_BABE, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0000_0002, 32'h8765_4321, 4, 5, 4, 1'b0, 32'h8765_4321, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_004C, 32'h0000_0003, 32'h3333_3333, 0, 5, 4, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0050, 32'h0000_0004, 32'h2222_2222, 2, 3, 2, 1'b0, 32'h2222_2222, 1'b1};

    rst       = 1'b1;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_dout  = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_bus_req", {31'd0, bus_req}, 32'd0);
    chk("reset_bus_we", {31'd0, bus_we}, 32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    chk("reset_mem_din", mem_din, 32'd0);
    chk("reset_fault", {31'd0, mem_fault}, 32'd0);
    chk("reset_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      if (POSTED && vecs[i].wen) continue;
      run_vec(i, vecs[i]);
    end
    chk("sb_drained", sb.size(), 32'd0);

    reset_seq();
`ifdef DMEM_WBUF_EN
    posted_seq();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
